// File: rtl/qpu_trace_pkg.sv
// Shared definitions for the QPU trace transmitter: frame constants,
// snapshot layout, FSM state encoding and the frame byte selector.
package qpu_trace_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 12;
  localparam int         SNAP_BITS   = 82;

  // UART framing states
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } txState_t;

  // One captured QPU snapshot; first field lands in the most significant bits
  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  status;
    logic [31:0] alpha;
    logic [31:0] beta;
  } snapshot_t;

  // Picks byte idx of the outgoing frame: sync, pc, status, alpha, beta (MSB first)
  function automatic logic [7:0] frameByte(input snapshot_t s, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = s.pc[15:8];
      4'd2:    b = s.pc[7:0];
      4'd3:    b = {6'b0, s.status};
      4'd4:    b = s.alpha[31:24];
      4'd5:    b = s.alpha[23:16];
      4'd6:    b = s.alpha[15:8];
      4'd7:    b = s.alpha[7:0];
      4'd8:    b = s.beta[31:24];
      4'd9:    b = s.beta[23:16];
      4'd10:   b = s.beta[15:8];
      4'd11:   b = s.beta[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/qpu_trace_fifo.sv
// Small snapshot FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; pointers wrap modulo DEPTH (any depth).
module qpu_trace_fifo
  import qpu_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [SNAP_BITS-1:0] i_data,
  input  logic                 i_pop,
  output logic [SNAP_BITS-1:0] o_data,
  output logic                 o_empty,
  output logic                 o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [SNAP_BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wrPtr;
  logic [PW-1:0]        r_rdPtr;
  logic [CW-1:0]        r_count;
  logic                 w_doPush;
  logic                 w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_CNT);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_data   = r_mem[r_rdPtr];

  // Storage array; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping with explicit modulo-DEPTH wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/qpu_trace_tx.sv
// QPU trace transmitter: captures a snapshot on every QPU completion and
// streams it out as a 12-byte UART 8N1 frame. The stop bit of each
// non-final byte absorbs the LOAD cycle so bytes run back to back.
module qpu_trace_tx
  import qpu_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] pc,
  input  logic [1:0]  q_status,
  input  logic        q_busy,
  input  logic [31:0] q_alpha,
  input  logic [31:0] q_beta,
  output logic        tx,
  output logic        tx_busy,
  output logic        overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       LAST_BYTE   = 4'(FRAME_BYTES - 1);

  txState_t             r_state;
  snapshot_t            r_frame;
  logic [7:0]           r_shift;
  logic [CNT_W-1:0]     r_clkCnt;
  logic [2:0]           r_bitIdx;
  logic [3:0]           r_byteIdx;
  logic                 r_tx;
  logic                 r_txBusy;
  logic                 r_overflow;
  logic                 r_busyD;

  logic                 w_complete;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic [SNAP_BITS-1:0] w_snapIn;
  logic [SNAP_BITS-1:0] w_fifoData;
  logic                 w_unusedPc;

  assign w_unusedPc = ^pc[31:16];
  assign w_snapIn   = {pc[15:0], q_status, q_alpha, q_beta};
  assign w_complete = r_busyD && !q_busy;
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_push     = w_complete && enable;

  assign tx       = r_tx;
  assign tx_busy  = r_txBusy;
  assign overflow = r_overflow;

  qpu_trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_snapIn),
    .i_pop   (w_pop),
    .o_data  (w_fifoData),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Completion edge detection and sticky overflow on a dropped snapshot
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busyD    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_busyD <= q_busy;
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // UART framing FSM with registered tx and tx_busy
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_frame   <= '0;
      r_shift   <= '0;
      r_clkCnt  <= '0;
      r_bitIdx  <= '0;
      r_byteIdx <= '0;
      r_tx      <= 1'b1;
      r_txBusy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx     <= 1'b1;
          r_txBusy <= 1'b0;
          r_clkCnt <= '0;
          if (!w_empty) begin
            r_frame   <= w_fifoData;
            r_byteIdx <= '0;
            r_txBusy  <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          r_shift  <= frameByte(r_frame, r_byteIdx);
          r_tx     <= 1'b0;
          r_clkCnt <= '0;
          r_state  <= START;
        end
        START: begin
          if (r_clkCnt == CNT_LAST) begin
            r_clkCnt <= '0;
            r_tx     <= r_shift[0];
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bitIdx <= '0;
            r_state  <= DATA;
          end else begin
            r_clkCnt <= r_clkCnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_clkCnt == CNT_LAST) begin
            r_clkCnt <= '0;
            if (r_bitIdx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_clkCnt <= r_clkCnt + CNT_W'(1);
          end
        end
        STOP: begin
          if ((r_byteIdx != LAST_BYTE) && (r_clkCnt == CNT_PRELAST)) begin
            r_clkCnt  <= '0;
            r_byteIdx <= r_byteIdx + 4'd1;
            r_state   <= LOAD;
          end else if ((r_byteIdx == LAST_BYTE) && (r_clkCnt == CNT_LAST)) begin
            r_clkCnt <= '0;
            r_txBusy <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_clkCnt <= r_clkCnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qpu_trace_tx.sv
// Bench for qpu_trace_tx: a cycle-level waveform model built from snapshot
// queues, a UART byte decoder and directed scenarios with literal values.
module tb_qpu_trace_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        enable   = 1'b0;
  logic [31:0] pc       = '0;
  logic [1:0]  q_status = '0;
  logic        q_busy   = 1'b0;
  logic [31:0] q_alpha  = '0;
  logic [31:0] q_beta   = '0;
  logic        tx;
  logic        tx_busy;
  logic        overflow;

  int checks    = 0;
  int failures  = 0;
  int busyCount = 0;
  int lowCount  = 0;

  qpu_trace_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pc       (pc),
    .q_status (q_status),
    .q_busy   (q_busy),
    .q_alpha  (q_alpha),
    .q_beta   (q_beta),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .overflow (overflow)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: snapshot queue plus per-cycle {tx, tx_busy} schedule
  typedef struct {
    logic [15:0] pc;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] b;
  } snap_t;

  snap_t      fifoQ[$];
  logic [1:0] wave[$];
  logic       expTx      = 1'b1;
  logic       expBusy    = 1'b0;
  logic       expOvf     = 1'b0;
  logic       prevBusy   = 1'b0;
  bit         modelValid = 1'b0;

  // A frame is: one LOAD cycle, 12 bytes x 10 bits x CPB cycles, one idle cycle
  task automatic loadFrame(input snap_t s);
    logic [95:0] v;
    logic [7:0]  by;
    v = {8'hA5, s.pc, 6'b0, s.st, s.a, s.b};
    wave.push_back(2'b11);
    for (int i = 0; i < 12; i++) begin
      by = v[95 - 8*i -: 8];
      for (int c = 0; c < CPB; c++) wave.push_back(2'b01);
      for (int k = 0; k < 8; k++)
        for (int c = 0; c < CPB; c++) wave.push_back({by[k], 1'b1});
      for (int c = 0; c < CPB; c++) wave.push_back(2'b11);
    end
    wave.push_back(2'b10);
  endtask

  // Model advances on every rising edge using inputs driven at the falling edge
  always @(posedge clk) begin
    if (!reset) begin
      fifoQ.delete();
      wave.delete();
      prevBusy   = 1'b0;
      expTx      = 1'b1;
      expBusy    = 1'b0;
      expOvf     = 1'b0;
      modelValid = 1'b1;
    end else begin
      if (wave.size() == 0 && fifoQ.size() > 0) loadFrame(fifoQ.pop_front());
      if (wave.size() > 0) begin
        {expTx, expBusy} = wave.pop_front();
      end else begin
        expTx   = 1'b1;
        expBusy = 1'b0;
      end
      if (prevBusy && !q_busy && enable) begin
        if (fifoQ.size() < DEPTH) fifoQ.push_back('{pc[15:0], q_status, q_alpha, q_beta});
        else expOvf = 1'b1;
      end
      prevBusy = q_busy;
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model_tx", 32'(tx), 32'(expTx));
      checkOutput("model_tx_busy", 32'(tx_busy), 32'(expBusy));
      checkOutput("model_overflow", 32'(overflow), 32'(expOvf));
    end
  end

  // Activity counters for quiet-window checks
  always @(negedge clk) begin
    if (tx_busy === 1'b1) busyCount++;
    if (tx === 1'b0) lowCount++;
  end

  // UART 8N1 decoder sampling mid-bit
  logic [7:0] rxBytes[$];
  logic [7:0] rxShift;
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          rxShift[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        rxBytes.push_back(rxShift);
      end
    end
  end

  // One QPU completion: busy high for a cycle, then low
  task automatic applyStimulus(input logic [15:0] pcLo, input logic [1:0] st,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    pc       = {16'h1234, pcLo};
    q_status = st;
    q_alpha  = a;
    q_beta   = b;
    q_busy   = 1'b1;
    @(negedge clk);
    q_busy = 1'b0;
  endtask

  // Fetch a decoded byte, or a sentinel if it never arrived
  function automatic logic [31:0] rxAt(input int i);
    if (i < rxBytes.size()) return 32'(rxBytes[i]);
    return 32'hFFFF_FFFF;
  endfunction

  logic [7:0] exp034 [12] = '{8'hA5, 8'h00, 8'h08, 8'h01, 8'h00, 8'h00,
                              8'hB5, 8'h05, 8'h00, 8'h00, 8'hB5, 8'h05};

  // Watchdog
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    int lat;
    int len;
    int wait5;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("reset_tx", 32'(tx), 32'd1);
      checkOutput("reset_tx_busy", 32'(tx_busy), 32'd0);
      checkOutput("reset_overflow", 32'(overflow), 32'd0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // q_busy held constant low then high: no capture
    enable    = 1'b1;
    busyCount = 0;
    lowCount  = 0;
    repeat (100) @(negedge clk);
    q_busy = 1'b1;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    q_busy = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("const_busy_frames", 32'(busyCount), 32'd0);
    checkOutput("const_busy_txlow", 32'(lowCount), 32'd0);

    // Single frame: latency, length and byte content
    enable = 1'b1;
    rxBytes.delete();
    applyStimulus(16'h0008, 2'b01, 32'h0000B505, 32'h0000B505);
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("start_latency", 32'(lat), 32'd3);
    len = 0;
    while (tx_busy === 1'b1 && len < 1000) begin
      @(negedge clk);
      len++;
    end
    checkOutput("frame_length", 32'(len), 32'd480);
    repeat (10) @(negedge clk);
    checkOutput("frame_byte_count", 32'(rxBytes.size()), 32'd12);
    for (int i = 0; i < 12; i++) checkOutput("frame_byte", rxAt(i), 32'(exp034[i]));

    // Capture disabled: three completions produce nothing
    enable    = 1'b0;
    busyCount = 0;
    lowCount  = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0100 + 16'(i), 2'b10, 32'hCAFE0000, 32'h0000BEEF);
      repeat (4) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    checkOutput("disabled_frames", 32'(busyCount), 32'd0);
    checkOutput("disabled_txlow", 32'(lowCount), 32'd0);

    // Six completions 8 cycles apart: five frames, overflow, sixth dropped
    enable = 1'b1;
    rxBytes.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'h0010 + 16'(i), 2'(i), 32'h01000000 * i, 32'h00000100 + i);
      repeat (6) @(negedge clk);
    end
    checkOutput("overflow_set", 32'(overflow), 32'd1);
    repeat (2600) @(negedge clk);
    checkOutput("burst_byte_count", 32'(rxBytes.size()), 32'd60);
    for (int i = 0; i < 5; i++) begin
      checkOutput("burst_sync", rxAt(12*i), 32'h0000_00A5);
      checkOutput("burst_pc_lo", rxAt(12*i + 2), 32'h10 + 32'(i));
    end
    checkOutput("overflow_sticky", 32'(overflow), 32'd1);

    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("overflow_cleared", 32'(overflow), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Reset during byte 5 with two snapshots queued: abort, nothing more sent
    rxBytes.delete();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0200 + 16'(i), 2'b11, 32'hA0A0A0A0, 32'h5F5F5F5F);
    end
    wait5 = 0;
    while (rxBytes.size() < 5 && wait5 < 1000) begin
      @(negedge clk);
      wait5++;
    end
    checkOutput("abort_reached_byte5", 32'(rxBytes.size()), 32'd5);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_tx_high", 32'(tx), 32'd1);
    checkOutput("abort_tx_busy_low", 32'(tx_busy), 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    busyCount = 0;
    lowCount  = 0;
    repeat (600) @(negedge clk);
    checkOutput("abort_no_frames", 32'(busyCount), 32'd0);
    checkOutput("abort_no_txlow", 32'(lowCount), 32'd0);
    checkOutput("abort_byte_count", 32'(rxBytes.size()), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
